// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data_memory_bank slice:
//   - dmem_state_e : sweep/run FSM state encoding
//   - idxWidth()   : word-index width for a given DEPTH
//   - mergeByte()  : byte-lane merge used by the write and forwarding paths
// ---------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } dmem_state_e;

   // Index width for the array; DEPTH >= 2 so the result is at least 1.
   function automatic int idxWidth(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // Selects the new byte when its lane is enabled, the old byte otherwise.
   function automatic logic [7:0] mergeByte(input logic [7:0] oldByte,
                                            input logic [7:0] newByte,
                                            input logic       en);
      return en ? newByte : oldByte;
   endfunction

endpackage

// File: rtl/data_memory_bank_if.sv
// ---------------------------------------------------------------------------
// data_memory_bank_if
// MEM-stage access bus of the data memory bank.
//   master : drives MemRead, MemWrite, ByteEn, DataAddress, DataIn
//            observes DataOut, ReadValid, Ready, AddrError
//   slave  : the memory bank (directions reversed)
// ---------------------------------------------------------------------------
interface data_memory_bank_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic                  MemRead;
   logic                  MemWrite;
   logic [DATA_W/8-1:0]   ByteEn;
   logic [ADDR_W-1:0]     DataAddress;
   logic [DATA_W-1:0]     DataIn;
   logic [DATA_W-1:0]     DataOut;
   logic                  ReadValid;
   logic                  Ready;
   logic                  AddrError;

   modport master (
      output MemRead, MemWrite, ByteEn, DataAddress, DataIn,
      input  DataOut, ReadValid, Ready, AddrError
   );

   modport slave (
      input  MemRead, MemWrite, ByteEn, DataAddress, DataIn,
      output DataOut, ReadValid, Ready, AddrError
   );
endinterface

// File: rtl/dmem_read_pipe.sv
// ---------------------------------------------------------------------------
// dmem_read_pipe
// LATENCY-deep register stage carrying read data, valid and error flag.
// Data registers only load when a valid result enters them, so the final
// stage holds the last result between reads.
//   CLK, RST                   : clock, async active-high clear
//   inValid, inData, inErr     : result produced at the acceptance edge
//   outValid, outData, outErr  : result LATENCY-1 edges later
// ---------------------------------------------------------------------------
module dmem_read_pipe #(
   parameter int DATA_W  = 16,
   parameter int LATENCY = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              inValid,
   input  logic [DATA_W-1:0] inData,
   input  logic              inErr,
   output logic              outValid,
   output logic [DATA_W-1:0] outData,
   output logic              outErr
);
   logic [LATENCY-1:0] validQ;
   logic [LATENCY-1:0] errQ;
   logic [DATA_W-1:0]  dataQ [LATENCY];

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples the previous stage's pre-edge value.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         validQ <= '0;
         errQ   <= '0;
         for (int i = 0; i < LATENCY; i++) dataQ[i] <= '0;
      end else begin
         validQ[0] <= inValid;
         errQ[0]   <= inValid & inErr;
         if (inValid) dataQ[0] <= inData;
         for (int i = 1; i < LATENCY; i++) begin
            validQ[i] <= validQ[i-1];
            errQ[i]   <= errQ[i-1];
            if (validQ[i-1]) dataQ[i] <= dataQ[i-1];
         end
      end
   end

   assign outValid = validQ[LATENCY-1];
   assign outErr   = errQ[LATENCY-1];
   assign outData  = dataQ[LATENCY-1];
endmodule

// File: rtl/data_memory_bank.sv
// ---------------------------------------------------------------------------
// data_memory_bank
// Synchronous-read data RAM for the MEM stage: byte-lane writes, 1- or
// 2-cycle read latency with ReadValid, out-of-range detection, and a
// post-reset sweep that writes INIT_VALUE everywhere before Ready rises.
//   CLK, RST : clock, async active-high reset
//   bus      : data_memory_bank_if.slave (requests in, DataOut/ReadValid/
//              Ready/AddrError out)
// Build option: define DMEM_FWD_EN to return the byte-merged new word on a
// same-cycle read/write of one index (default returns the old word).
// ---------------------------------------------------------------------------
module data_memory_bank
   import dmem_pkg::*;
#(
   parameter int                DATA_W       = 16,
   parameter int                ADDR_W       = 16,
   parameter int                DEPTH        = 256,
   parameter int                READ_LATENCY = 1,
   parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
   input  logic                CLK,
   input  logic                RST,
   data_memory_bank_if.slave   bus
);
   localparam int IDX_W = idxWidth(DEPTH);
   localparam int NBYTE = DATA_W / 8;
   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   dmem_state_e       state;
   logic [IDX_W-1:0]  cnt;
   logic              readyQ;
   logic              wrErrQ;

   logic [IDX_W-1:0]  idx;
   logic              inRange;
   logic              rdAccept;
   logic              wrAccept;
   logic [DATA_W-1:0] oldWord;
   logic [DATA_W-1:0] mergedWord;
   logic [DATA_W-1:0] rdWord;

   logic              pipeValid;
   logic [DATA_W-1:0] pipeData;
   logic              pipeErr;

   assign idx      = bus.DataAddress[IDX_W-1:0];
   assign inRange  = {1'b0, bus.DataAddress} < DEPTH_EXT;
   assign rdAccept = readyQ & bus.MemRead;
   assign wrAccept = readyQ & bus.MemWrite & inRange;
   assign oldWord  = mem[idx];

   // NOTE: every always_comb output gets a default first so no latch forms.
   always_comb begin
      mergedWord = oldWord;
      for (int k = 0; k < NBYTE; k++)
         mergedWord[8*k +: 8] = mergeByte(oldWord[8*k +: 8], bus.DataIn[8*k +: 8], bus.ByteEn[k]);
   end

   always_comb begin
      rdWord = '0;
      if (inRange) begin
`ifdef DMEM_FWD_EN
         rdWord = wrAccept ? mergedWord : oldWord;
`else
         rdWord = oldWord;
`endif
      end
   end

   // Sweep FSM, Ready and the write-side range error.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= INIT;
         cnt    <= '0;
         readyQ <= 1'b0;
         wrErrQ <= 1'b0;
      end else begin
         wrErrQ <= readyQ & bus.MemWrite & ~inRange;
         case (state)
            INIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == IDX_W'(DEPTH - 1)) begin
                  state  <= RUN;
                  readyQ <= 1'b1;
               end
            end
            RUN:     state <= RUN;
            default: state <= INIT;
         endcase
      end
   end

   // NOTE: the array has no reset; the sweep rewrites it after every RST.
   // While RST is held the FSM sits at INIT/cnt=0, so it only rewrites
   // word 0 with INIT_VALUE, which the sweep does first anyway.
   always_ff @(posedge CLK) begin
      if (state == INIT)
         mem[cnt] <= INIT_VALUE;
      else if (wrAccept)
         mem[idx] <= mergedWord;
   end

   dmem_read_pipe #(
      .DATA_W  (DATA_W),
      .LATENCY (READ_LATENCY)
   ) u_read_pipe (
      .CLK      (CLK),
      .RST      (RST),
      .inValid  (rdAccept),
      .inData   (rdWord),
      .inErr    (~inRange),
      .outValid (pipeValid),
      .outData  (pipeData),
      .outErr   (pipeErr)
   );

   assign bus.DataOut   = pipeData;
   assign bus.ReadValid = pipeValid;
   assign bus.Ready     = readyQ;
   assign bus.AddrError = wrErrQ | pipeErr;
endmodule
